// File: rtl/ext_obi_responder.sv
// OBI responder terminating the external crossbar slave port: word-addressed
// scratch memory, fixed-latency in-order responses, stall injection, OOB errors.

package ext_obi_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_stage_t;

endpackage

module ext_obi_responder
  import ext_obi_responder_pkg::*;
#(
  parameter int unsigned       NUM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0,
  parameter int unsigned       LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    slave_req_i,
  output obi_resp_t   slave_resp_o,
  input  logic        stall_i,
  output logic        err_o,
  output logic [15:0] oob_count_o
);

  localparam int unsigned       IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned       CNT_W   = 16;
  localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(NUM_WORDS * 4);
  localparam logic [DATA_W-1:0] ERR_PAT = 32'hBADCAB1E;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic              gnt_c;
  logic              hs_c;
  logic [ADDR_W-1:0] off_c;
  logic              in_range_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rd_word_c;

  logic [DATA_W-1:0] mem_q [NUM_WORDS];

  rsp_stage_t        pipe_q [LATENCY];
  rsp_stage_t        pipe_d [LATENCY];
  rsp_stage_t        stage0_c;

  logic [CNT_W-1:0]  oob_count_q;
  logic [CNT_W-1:0]  oob_count_d;

  // Address decode and handshake detection
  always_comb begin
    gnt_c      = slave_req_i.req & ~stall_i;
    hs_c       = slave_req_i.req & gnt_c;
    off_c      = slave_req_i.addr - BASE_ADDR;
    in_range_c = (off_c < SPAN);
    idx_c      = off_c[2 +: IDX_W];
    rd_word_c  = mem_q[idx_c];
  end

  // Scratch memory: byte-enabled writes, contents survive reset
  always_ff @(posedge clk_i) begin
    if (hs_c && slave_req_i.we && in_range_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (slave_req_i.be[b]) begin
          mem_q[idx_c][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  // Stage-0 payload; idle cycles carry zeros so rdata stays 0 when not valid
  always_comb begin
    stage0_c = '0;
    if (hs_c) begin
      stage0_c.valid = 1'b1;
      stage0_c.err   = ~in_range_c;
      if (!slave_req_i.we) begin
        stage0_c.rdata = in_range_c ? rd_word_c : ERR_PAT;
      end
    end
  end

  // Response shift register and saturating out-of-range counter
  always_comb begin
    pipe_d[0] = stage0_c;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
    oob_count_d = oob_count_q;
    if (hs_c && !in_range_c && (oob_count_q != CNT_MAX)) begin
      oob_count_d = oob_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
      oob_count_q <= '0;
    end else begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
      oob_count_q <= oob_count_d;
    end
  end

  // gnt is combinational by protocol; the response side comes from the last stage
  always_comb begin
    slave_resp_o.gnt    = gnt_c;
    slave_resp_o.rvalid = pipe_q[LATENCY-1].valid;
    slave_resp_o.rdata  = pipe_q[LATENCY-1].rdata;
    err_o               = pipe_q[LATENCY-1].err;
    oob_count_o         = oob_count_q;
  end

endmodule

// File: tb/tb_ext_obi_responder.sv
// Bench for ext_obi_responder: three instances (latency 1, 4, 3) share one
// stimulus stream and are compared every cycle against a transaction-level model.

module tb_ext_obi_responder;
  import ext_obi_responder_pkg::*;

  localparam int          NW   = 64;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SPAN = 32'(NW * 4);
  localparam int          LAT [3] = '{1, 4, 3};

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        e;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  obi_req_t    rq;
  obi_resp_t   resp [3];
  logic        err  [3];
  logic [15:0] oob  [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ext_obi_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(rq), .slave_resp_o(resp[0]),
    .stall_i(stall), .err_o(err[0]), .oob_count_o(oob[0]));
  ext_obi_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .LATENCY(4)) u_lat4 (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(rq), .slave_resp_o(resp[1]),
    .stall_i(stall), .err_o(err[1]), .oob_count_o(oob[1]));
  ext_obi_responder #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(rq), .slave_resp_o(resp[2]),
    .stall_i(stall), .err_o(err[2]), .oob_count_o(oob[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Transaction model: memory image, OOB count, and expected responses keyed by cycle
  logic [31:0] mem_m [NW];
  int          oob_m = 0;
  logic        exp_v [3][16];
  logic        exp_e [3][16];
  logic [31:0] exp_d [3][16];
  int          cyc = 0;
  int          hs_log [$];
  ent_t        log0 [$], log1 [$], log2 [$];
  int          gnt_low = 0;

  logic [31:0] off, rdv;
  logic        inr;
  int          s, w;

  task automatic clear_exp();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 16; j++) begin
        exp_v[i][j] = 1'b0; exp_e[i][j] = 1'b0; exp_d[i][j] = '0;
      end
  endtask

  initial clear_exp();

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      clear_exp();
      oob_m = 0;
    end else begin
      for (int i = 0; i < 3; i++)
        check($sformatf("gnt_L%0d", LAT[i]), 32'(resp[i].gnt), 32'(rq.req & ~stall));
      if (rq.req && !resp[0].gnt) gnt_low++;
      if (rq.req && !stall) begin
        off = rq.addr - BASE;
        inr = off < SPAN;
        w   = int'(off / 4);
        rdv = 32'h0;
        if (!rq.we) rdv = inr ? mem_m[w] : 32'hBADCAB1E;
        else if (inr)
          for (int b = 0; b < 4; b++)
            if (rq.be[b]) mem_m[w][8*b +: 8] = rq.wdata[8*b +: 8];
        if (!inr && oob_m < 65535) oob_m++;
        // a handshake sampled at edge e is visible right after edge e+L-1
        for (int i = 0; i < 3; i++) begin
          s = (cyc + LAT[i] - 1) % 16;
          exp_v[i][s] = 1'b1; exp_d[i][s] = rdv; exp_e[i][s] = ~inr;
        end
        hs_log.push_back(cyc);
      end
    end
    #1;
    s = cyc % 16;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rvalid_L%0d", LAT[i]), 32'(resp[i].rvalid), 32'(exp_v[i][s]));
      check($sformatf("err_L%0d", LAT[i]), 32'(err[i]), 32'(exp_v[i][s] & exp_e[i][s]));
      if (exp_v[i][s])
        check($sformatf("rdata_L%0d", LAT[i]), resp[i].rdata, exp_d[i][s]);
      check($sformatf("oob_L%0d", LAT[i]), 32'(oob[i]), 32'(oob_m));
      if (resp[i].rvalid) begin
        if (i == 0) log0.push_back('{cyc, resp[i].rdata, err[i]});
        else if (i == 1) log1.push_back('{cyc, resp[i].rdata, err[i]});
        else log2.push_back('{cyc, resp[i].rdata, err[i]});
      end
      exp_v[i][s] = 1'b0;
    end
  end

  // Initiator rule: a request that was not granted stays unchanged
  obi_req_t p_rq;
  logic     p_pend = 1'b0;
  always @(posedge clk) begin
    if (rst_n && p_pend)
      assert (rq == p_rq) else $error("FAIL stall_stable: request changed while waiting for gnt");
    p_pend = rst_n && rq.req && !resp[0].gnt;
    p_rq   = rq;
  end

  task automatic clear_logs();
    log0.delete(); log1.delete(); log2.delete(); hs_log.delete(); gnt_low = 0;
  endtask

  task automatic req_cyc(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd);
    @(negedge clk);
    rq.req = 1'b1; rq.we = we; rq.be = be; rq.addr = addr; rq.wdata = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rq.req = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; rq = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_rvalid", 32'(resp[i].rvalid), 32'h0);
      check("reset_rdata", resp[i].rdata, 32'h0);
      check("reset_err", 32'(err[i]), 32'h0);
      check("reset_oob", 32'(oob[i]), 32'h0);
    end
    rst_n = 1'b1;

    // prefill every word with its index
    for (int i = 0; i < NW; i++) req_cyc(1'b1, 4'hF, BASE + 32'(4 * i), 32'(i));
    idle(6);

    // 8 back-to-back reads of words 0..7
    clear_logs();
    for (int i = 0; i < 8; i++) req_cyc(1'b0, 4'h0, BASE + 32'(4 * i), 32'h0);
    idle(8);
    check("b2b_count_L4", 32'(log1.size()), 32'd8);
    if (log1.size() == 8 && hs_log.size() == 8) begin
      check("b2b_first_L4", 32'(log1[0].cyc), 32'(hs_log[0] + 3));
      for (int k = 0; k < 8; k++) begin
        check("b2b_data_L4", log1[k].d, 32'(k));
        check("b2b_cycle_L4", 32'(log1[k].cyc), 32'(log1[0].cyc + k));
      end
    end

    // full write then read of BASE+0x10
    clear_logs();
    req_cyc(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
    req_cyc(1'b0, 4'h0, BASE + 32'h10, 32'h0);
    idle(6);
    check("wr_rd_count_L1", 32'(log0.size()), 32'd2);
    if (log0.size() == 2 && hs_log.size() == 2) begin
      check("wr_rdata_L1", log0[0].d, 32'h0);
      check("rd_rdata_L1", log0[1].d, 32'hDEADBEEF);
      check("rd_err_L1", 32'(log0[1].e), 32'h0);
      check("rd_latency_L1", 32'(log0[1].cyc), 32'(hs_log[1]));
    end

    // partial write over 32'hAABBCCDD
    clear_logs();
    req_cyc(1'b1, 4'hF, BASE + 32'h24, 32'hAABBCCDD);
    req_cyc(1'b1, 4'b0101, BASE + 32'h24, 32'h11223344);
    req_cyc(1'b1, 4'h0, BASE + 32'h24, 32'hFFFFFFFF);
    req_cyc(1'b0, 4'h0, BASE + 32'h24, 32'h0);
    idle(6);
    if (log0.size() == 4) check("partial_rdata", log0[3].d, 32'hAA22CC44);
    else check("partial_count", 32'(log0.size()), 32'd4);

    // stall held three cycles on a read of word 2
    clear_logs();
    @(negedge clk);
    stall = 1'b1; rq.req = 1'b1; rq.we = 1'b0; rq.be = 4'h0; rq.addr = BASE + 32'h8; rq.wdata = '0;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    idle(7);
    check("stall_gnt_low", 32'(gnt_low), 32'd3);
    check("stall_hs", 32'(hs_log.size()), 32'd1);
    check("stall_rvalid_L1", 32'(log0.size()), 32'd1);
    check("stall_rvalid_L4", 32'(log1.size()), 32'd1);
    if (log0.size() == 1) check("stall_rdata", log0[0].d, 32'd2);

    // out-of-range read above the window and write wrapping below it
    clear_logs();
    req_cyc(1'b0, 4'hF, BASE + SPAN, 32'h0);
    req_cyc(1'b1, 4'hF, BASE - 32'h4, 32'hFFFFFFFF);
    idle(6);
    check("oob_count", 32'(oob[0]), 32'd2);
    if (log0.size() == 2) begin
      check("oob_rd_data", log0[0].d, 32'hBADCAB1E);
      check("oob_rd_err", 32'(log0[0].e), 32'h1);
      check("oob_wr_err", 32'(log0[1].e), 32'h1);
    end else check("oob_resp_count", 32'(log0.size()), 32'd2);

    // read sweep: memory untouched by the dropped write
    clear_logs();
    for (int i = 0; i < NW; i++) req_cyc(1'b0, 4'h0, BASE + 32'(4 * i), 32'h0);
    idle(6);
    if (log0.size() == NW) begin
      check("sweep_w4", log0[4].d, 32'hDEADBEEF);
      check("sweep_w9", log0[9].d, 32'hAA22CC44);
      check("sweep_w63", log0[63].d, 32'd63);
    end else check("sweep_count", 32'(log0.size()), 32'(NW));

    // reset one cycle after two handshakes discards pending responses
    clear_logs();
    req_cyc(1'b1, 4'hF, BASE + 32'd80, 32'h5A5A0000);
    req_cyc(1'b0, 4'h0, BASE + 32'd80, 32'h0);
    @(negedge clk);
    rq.req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    idle(8);
    check("rst_drop_L4", 32'(log1.size()), 32'd0);
    check("rst_drop_L3", 32'(log2.size()), 32'd0);
    check("rst_oob", 32'(oob[0]), 32'd0);
    req_cyc(1'b0, 4'h0, BASE + 32'd80, 32'h0);
    idle(6);
    if (log2.size() == 1) check("retained_L3", log2[0].d, 32'h5A5A0000);
    else check("retained_count_L3", 32'(log2.size()), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
